// File: rtl/present_pkg.sv
// Shared PRESENT constants, the 4-bit S-box and the key-scheduler state encoding.
// The cipher round logic imports the same S-box so both sides stay in lockstep.
package present_pkg;

    localparam int KEY_W   = 32;
    localparam int BLK_W   = 16;
    localparam int N_RKEYS = 8;
    localparam int ROT     = 13;
    localparam int CNT_W   = 3;
    localparam int RC_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    function automatic logic [3:0] present_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_key_update.sv
// One key-register update step: rotate left, S-box the top nibble, fold in the round counter.
// Purely combinational so the encipher side can reuse it unchanged.
module present_key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [RC_W-1:0]  rc_i,
    output logic [KEY_W-1:0] key_o
);

    logic [KEY_W-1:0] rot_w;
    logic [KEY_W-1:0] upd_w;

    assign rot_w = {key_i[KEY_W-1-ROT:0], key_i[KEY_W-1 -: ROT]};

    always_comb begin
        upd_w                  = rot_w;
        upd_w[KEY_W-1 -: 4]    = present_sbox(rot_w[KEY_W-1 -: 4]);
        upd_w[6:3]             = rot_w[6:3] ^ rc_i;
    end

    assign key_o = upd_w;

endmodule

// File: rtl/present_key_scheduler.sv
// Iterative key scheduler: expands a master key into the round keys, one per clock,
// stored in reverse order (slot0 = last key) so the decipher can walk them upward.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | waiting for a master key; in_ready high
//  GEN   | one round key per edge, cnt = index of the key being produced
//  DONE  | rkeys_rev complete and frozen until out_ready
module present_key_scheduler
    import present_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [KEY_W-1:0]         key_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_RKEYS*BLK_W-1:0] rkeys_rev,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_RKEYS - 1);

    ks_state_e                state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [KEY_W-1:0]         key_q;
    logic [N_RKEYS*BLK_W-1:0] rkeys_q;
    logic                     out_valid_q;

    logic [KEY_W-1:0]         key_d;
    logic [CNT_W-1:0]         slot_idx;

    present_key_update u_key_update (
        .key_i (key_q),
        .rc_i  ({{(RC_W-CNT_W){1'b0}}, cnt_q}),
        .key_o (key_d)
    );

    // Key K(cnt+1) lands in slot N_RKEYS-1-cnt, giving reverse order in the buffer.
    assign slot_idx = CNT_LAST - cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            rkeys_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        key_q                              <= key_in;
                        rkeys_q[(N_RKEYS-1)*BLK_W +: BLK_W] <= key_in[KEY_W-1 -: BLK_W];
                        cnt_q                              <= CNT_W'(1);
                        state_q                            <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    key_q                             <= key_d;
                    rkeys_q[slot_idx*BLK_W +: BLK_W]  <= key_d[KEY_W-1 -: BLK_W];
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign rkeys_rev = rkeys_q;

endmodule
